rtl_id_stage: RTL and testbench
===============================

Name: rtl_id_stage

Overview:
- Decode/operand-fetch stage directly upstream of the 2R1W register file.
- Accepts fetched instructions from IF over valid/ready, drives register-file read addresses, and captures operands, rd and the sign-extended immediate into an ID/EX pipeline register.
- Applies writeback bypass, load-use stall and flush.

Parameters:
- ILEN, 32, instruction width; RISC-V field layout: rd [11:7], rs1 [19:15], rs2 [24:20], imm [31:20].
- PC_W, 32, program counter width.
- Data width is `XLEN and register address width is `REG_ADDR_W, both from defs.vh; x0 is `REG_ZERO.

Ports:
- clk  in  1  clock; all state updates at posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  IF holds a valid instruction.
- if_ready  out  1  ID accepts this cycle.
- if_instr  in  ILEN  instruction word.
- if_pc  in  PC_W  instruction PC.
- rf_raddr_a  out  `REG_ADDR_W  = if_instr[19:15]; combinational.
- rf_raddr_b  out  `REG_ADDR_W  = if_instr[24:20]; combinational.
- rf_rdata_a  in  `XLEN  register-file port A data; combinational.
- rf_rdata_b  in  `XLEN  register-file port B data.
- wb_we  in  1  same-cycle register-file write enable.
- wb_waddr  in  `REG_ADDR_W  writeback address.
- wb_wdata  in  `XLEN  writeback data.
- ex_load_pend  in  1  EX holds a load whose result is not yet available.
- ex_load_rd  in  `REG_ADDR_W  destination register of that load.
- flush  in  1  kill the ID/EX entry and refuse input this cycle.
- ex_valid  out  1  ID/EX entry valid.
- ex_ready  in  1  EX consumes the entry.
- ex_pc  out  PC_W  registered PC.
- ex_instr  out  ILEN  registered instruction.
- ex_rs1_val  out  `XLEN  registered operand A.
- ex_rs2_val  out  `XLEN  registered operand B.
- ex_rd  out  `REG_ADDR_W  registered rd.
- ex_imm  out  `XLEN  sign-extended instr[31:20].
- dbg_stall_cnt  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Reset (async, rst_n low):
  - ex_valid=0.
  - All ex_* data outputs = 0.
  - dbg_stall_cnt = 0.
  - Reset mid-transfer discards the entry; no partial state survives.
- Hazard (combinational):
  - load_use = if_valid & ex_load_pend & ex_load_rd != `REG_ZERO & (ex_load_rd == rs1 | ex_load_rd == rs2).
  - A source register equal to `REG_ZERO never raises a hazard.
- can_load = !ex_valid | ex_ready.
- if_ready = can_load & !hazard & !flush.
- Accept = if_valid & if_ready: at the next posedge the ID/EX register loads pc, instr, operands, rd and imm, and ex_valid goes to 1. Latency IF to EX is 1 cycle.
- If ex_valid & ex_ready & !accept, ex_valid goes to 0.
- If ex_valid & !ex_ready, all ex_* outputs hold stable. EX-side forwarding for later writes is EX's responsibility.
- Flush has priority over everything: ex_valid goes to 0 next cycle and no instruction is accepted in the flush cycle.
- Operand select, per port:
  - If the source address equals `REG_ZERO, capture 0.
  - Otherwise, if bypass applies (see Optional Feature), capture wb_wdata.
  - Otherwise capture rf_rdata.
- ex_imm = {{(`XLEN-12){instr[31]}}, instr[31:20]}.
- dbg_stall_cnt increments each cycle where if_valid & hazard & !flush. It saturates at 16'hFFFF; no wrap.
- No state machine beyond the ID/EX valid bit. Throughput is 1 instruction per cycle absent hazards and backpressure.

Optional Feature:
- Macro: ID_BYPASS_EN.
- Defined:
  - If wb_we & wb_waddr != `REG_ZERO & wb_waddr == source address, capture wb_wdata in the same cycle.
  - hazard = load_use only.
- Undefined:
  - No bypass.
  - hazard = load_use | raw_wb, where raw_wb = if_valid & wb_we & wb_waddr != `REG_ZERO & wb_waddr matches rs1 or rs2.
  - One stall cycle results; the instruction is accepted next cycle, after the write has landed.

Test Plan:
- Plain accept: if_instr with rs1=3, rs2=4; rf returns 0x11 and 0x22; ex_ready=1 -> one cycle later ex_valid=1, ex_rs1_val=0x11, ex_rs2_val=0x22; imm 0xFFF gives ex_imm=0xFFFFFFFF.
- Writeback collision: rs1=5, wb_we=1, wb_waddr=5, wb_wdata=0xABCD, rf_rdata_a=0 ->
  - with ID_BYPASS_EN: accept same cycle, ex_rs1_val=0xABCD, dbg_stall_cnt unchanged;
  - without it: if_ready=0 for 1 cycle, dbg_stall_cnt=1, then accept.
- x0 source and destination: rs1=0, rf_rdata_a=0xDEAD, wb_we=1 with waddr=0 -> ex_rs1_val=0, no stall.
- Load-use: ex_load_pend=1, ex_load_rd=7, rs2=7, held for 2 cycles -> if_ready=0 for both cycles, dbg_stall_cnt=2; accept on the cycle ex_load_pend falls.
- Backpressure and flush:
  - ex_ready=0 for 3 cycles with a valid entry -> ex_* stable and if_ready=0.
  - Then flush=1 -> ex_valid=0 next cycle and the IF instruction is not accepted.
  - Assert rst_n low mid-stall -> ex_valid=0 immediately.

Source files
------------

// File: rtl/rtl_id_stage.sv
// rtl_id_stage: decode/operand-fetch into the ID/EX register with load-use/flush handling; `define ID_BYPASS_EN for same-cycle writeback bypass.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef REG_ZERO
`define REG_ZERO {`REG_ADDR_W{1'b0}}
`endif

module rtl_id_stage #(
    parameter int ILEN = 32,
    parameter int PC_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [ILEN-1:0]        if_instr,
    input  logic [PC_W-1:0]        if_pc,
    output logic [`REG_ADDR_W-1:0] rf_raddr_a,
    output logic [`REG_ADDR_W-1:0] rf_raddr_b,
    input  logic [`XLEN-1:0]       rf_rdata_a,
    input  logic [`XLEN-1:0]       rf_rdata_b,
    input  logic                   wb_we,
    input  logic [`REG_ADDR_W-1:0] wb_waddr,
    input  logic [`XLEN-1:0]       wb_wdata,
    input  logic                   ex_load_pend,
    input  logic [`REG_ADDR_W-1:0] ex_load_rd,
    input  logic                   flush,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [PC_W-1:0]        ex_pc,
    output logic [ILEN-1:0]        ex_instr,
    output logic [`XLEN-1:0]       ex_rs1_val,
    output logic [`XLEN-1:0]       ex_rs2_val,
    output logic [`REG_ADDR_W-1:0] ex_rd,
    output logic [`XLEN-1:0]       ex_imm,
    output logic [15:0]            dbg_stall_cnt
);
`ifdef ID_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    logic [`REG_ADDR_W-1:0] rs1, rs2;
    logic load_use, wb_hit_a, wb_hit_b, hazard, can_load, accept;
    logic [`XLEN-1:0] op_a, op_b, imm;
    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];
    assign rf_raddr_a = rs1;
    assign rf_raddr_b = rs2;
    assign load_use = if_valid & ex_load_pend & (ex_load_rd != `REG_ZERO) &
                      ((ex_load_rd == rs1) | (ex_load_rd == rs2));
    assign wb_hit_a = wb_we & (wb_waddr != `REG_ZERO) & (wb_waddr == rs1);
    assign wb_hit_b = wb_we & (wb_waddr != `REG_ZERO) & (wb_waddr == rs2);
    // Without the bypass, a same-cycle write to a source stalls one cycle so the RF read sees it.
    assign hazard = load_use | (~BYP & if_valid & (wb_hit_a | wb_hit_b));
    assign can_load = ~ex_valid | ex_ready;
    assign if_ready = can_load & ~hazard & ~flush;
    assign accept = if_valid & if_ready;
    assign op_a = (rs1 == `REG_ZERO) ? '0 : (BYP & wb_hit_a) ? wb_wdata : rf_rdata_a;
    assign op_b = (rs2 == `REG_ZERO) ? '0 : (BYP & wb_hit_b) ? wb_wdata : rf_rdata_b;
    assign imm = {{(`XLEN-12){if_instr[31]}}, if_instr[31:20]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_instr   <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_rd      <= '0;
            ex_imm     <= '0;
        end else begin
            ex_valid <= flush ? 1'b0 : accept ? 1'b1 : ex_ready ? 1'b0 : ex_valid;
            if (accept) begin
                ex_pc      <= if_pc;
                ex_instr   <= if_instr;
                ex_rs1_val <= op_a;
                ex_rs2_val <= op_b;
                ex_rd      <= if_instr[11:7];
                ex_imm     <= imm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dbg_stall_cnt <= '0;
        else if (if_valid & hazard & ~flush & ~&dbg_stall_cnt)
            dbg_stall_cnt <= dbg_stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_rtl_id_stage.sv
// tb_rtl_id_stage: vector table, directed hazard/flush/reset sequences and random traffic against a reference model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

module tb_rtl_id_stage;
`ifdef ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int XW = `XLEN;
    localparam int AW = `REG_ADDR_W;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic if_valid, if_ready, wb_we, ex_load_pend, flush, ex_valid, ex_ready;
    logic [31:0] if_instr, if_pc, ex_pc, ex_instr;
    logic [AW-1:0] rf_raddr_a, rf_raddr_b, wb_waddr, ex_load_rd, ex_rd;
    logic [XW-1:0] rf_rdata_a, rf_rdata_b, wb_wdata, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [15:0] dbg_stall_cnt;

    rtl_id_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .ex_load_pend(ex_load_pend), .ex_load_rd(ex_load_rd), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_imm(ex_imm),
        .dbg_stall_cnt(dbg_stall_cnt)
    );

    int tests = 0, fails = 0;
    logic m_valid;
    logic [31:0] m_pc, m_instr;
    logic [XW-1:0] m_a, m_b, m_imm;
    logic [AW-1:0] m_rd;
    logic [15:0] m_cnt;

    typedef struct {
        logic [31:0] instr;
        logic [XW-1:0] rda, rdb;
        logic we;
        logic [AW-1:0] wa;
        logic [XW-1:0] wd;
        logic rdy;
        logic [XW-1:0] e1, e2, eimm;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] rd);
        return {f7, r2, r1, 3'b000, rd, 7'h13};
    endfunction

    // Reference model: operand value a downstream stage should see for source r.
    function automatic logic [XW-1:0] m_op(input logic [4:0] r, input logic [XW-1:0] rf);
        if (r == 0) return '0;
        if (BYP && wb_we && wb_waddr == r) return wb_wdata;
        return rf;
    endfunction

    task automatic model_comb(output logic rdy, output logic haz);
        logic [4:0] r1, r2;
        logic lu, rw;
        r1 = if_instr[19:15];
        r2 = if_instr[24:20];
        lu = if_valid && ex_load_pend && ex_load_rd != 0 && (ex_load_rd == r1 || ex_load_rd == r2);
        rw = if_valid && wb_we && wb_waddr != 0 && (wb_waddr == r1 || wb_waddr == r2);
        haz = lu || (!BYP && rw);
        rdy = (!m_valid || ex_ready) && !haz && !flush;
    endtask

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_instr = 0; m_a = 0; m_b = 0; m_rd = 0; m_imm = 0; m_cnt = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic rdy, haz;
        model_comb(rdy, haz);
        #1;
        chk("if_ready", if_ready, rdy);
        chk("rf_raddr_a", rf_raddr_a, if_instr[19:15]);
        chk("rf_raddr_b", rf_raddr_b, if_instr[24:20]);
        @(posedge clk);
        if (flush) m_valid = 0;
        else if (if_valid && rdy) begin
            m_valid = 1;
            m_pc = if_pc;
            m_instr = if_instr;
            m_a = m_op(if_instr[19:15], rf_rdata_a);
            m_b = m_op(if_instr[24:20], rf_rdata_b);
            m_rd = if_instr[11:7];
            m_imm = XW'($signed(if_instr[31:20]));
        end else if (ex_ready) m_valid = 0;
        if (if_valid && haz && !flush && m_cnt != 16'hFFFF) m_cnt++;
        #1;
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_instr", ex_instr, m_instr);
        chk("ex_rs1_val", ex_rs1_val, m_a);
        chk("ex_rs2_val", ex_rs2_val, m_b);
        chk("ex_rd", ex_rd, m_rd);
        chk("ex_imm", ex_imm, m_imm);
        chk("dbg_stall_cnt", dbg_stall_cnt, m_cnt);
        @(negedge clk);
    endtask

    task automatic idle();
        if_valid = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0; ex_load_pend = 0;
        ex_load_rd = 0; flush = 0; ex_ready = 1;
    endtask

    initial begin
        logic [15:0] base;
        logic [31:0] x_instr;
        idle();
        if_instr = 0; if_pc = 0; rf_rdata_a = 0; rf_rdata_b = 0;
        model_reset();
        tbl[0] = '{mk(7'h00, 5'd4, 5'd3, 5'd1), 'h11, 'h22, 0, 0, 0, 1, 'h11, 'h22, 'h4};
        tbl[1] = '{mk(7'h7F, 5'd31, 5'd2, 5'd9), 'h5, 'h6, 0, 0, 0, 1, 'h5, 'h6, 'hFFFFFFFF};
        tbl[2] = '{mk(7'h00, 5'd6, 5'd0, 5'd0), 'hDEAD, 'h66, 1, 0, 'h1234, 1, 'h0, 'h66, 'h6};
        tbl[3] = '{mk(7'h00, 5'd9, 5'd5, 5'd2), 'h0, 'h99, 1, 5'd5, 'hABCD, BYP, 'hABCD, 'h99, 'h9};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_ex_valid", ex_valid, 0);
        chk("reset_ex_rs1", ex_rs1_val, 0);
        chk("reset_cnt", dbg_stall_cnt, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 4; i++) begin
            idle();
            if_valid = 1; if_instr = tbl[i].instr; if_pc = 32'h100 + 32'(i * 4);
            rf_rdata_a = tbl[i].rda; rf_rdata_b = tbl[i].rdb;
            wb_we = tbl[i].we; wb_waddr = tbl[i].wa; wb_wdata = tbl[i].wd;
            #1 chk("tbl_ready", if_ready, tbl[i].rdy);
            step();
            chk("tbl_valid", ex_valid, tbl[i].rdy);
            if (tbl[i].rdy) begin
                chk("tbl_rs1", ex_rs1_val, tbl[i].e1);
                chk("tbl_rs2", ex_rs2_val, tbl[i].e2);
                chk("tbl_imm", ex_imm, tbl[i].eimm);
            end
        end

        // Writeback collision on rs1
        idle();
        base = m_cnt;
        if_valid = 1; if_instr = mk(7'h00, 5'd0, 5'd5, 5'd3); if_pc = 32'h200;
        rf_rdata_a = 0; wb_we = 1; wb_waddr = 5; wb_wdata = 'hABCD;
        step();
        if (!BYP) begin
            chk("wb_stall_cnt", dbg_stall_cnt, base + 16'd1);
            wb_we = 0; rf_rdata_a = 'hABCD;
            step();
        end else chk("wb_byp_cnt", dbg_stall_cnt, base);
        chk("wb_valid", ex_valid, 1);
        chk("wb_rs1", ex_rs1_val, 'hABCD);

        // Load-use held two cycles
        idle();
        base = m_cnt;
        if_valid = 1; if_instr = mk(7'h00, 5'd7, 5'd1, 5'd4); if_pc = 32'h300;
        rf_rdata_a = 'h1; rf_rdata_b = 'h7;
        ex_load_pend = 1; ex_load_rd = 7;
        #1 chk("lu_ready0", if_ready, 0);
        step();
        chk("lu_ready1", if_ready, 0);
        step();
        chk("lu_cnt", dbg_stall_cnt, base + 16'd2);
        ex_load_pend = 0;
        step();
        chk("lu_accept", ex_valid, 1);
        chk("lu_pc", ex_pc, 32'h300);

        // Backpressure, flush, then reset mid-stall
        idle();
        x_instr = mk(7'h12, 5'd2, 5'd3, 5'd8);
        if_valid = 1; if_instr = x_instr; if_pc = 32'h400;
        step();
        if_instr = mk(7'h00, 5'd1, 5'd1, 5'd9); if_pc = 32'h404; ex_ready = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_ready", if_ready, 0);
            chk("bp_instr", ex_instr, x_instr);
            chk("bp_pc", ex_pc, 32'h400);
        end
        flush = 1;
        step();
        chk("flush_valid", ex_valid, 0);
        chk("flush_noacc_pc", ex_pc, 32'h400);
        flush = 0;
        step();
        chk("after_flush_pc", ex_pc, 32'h404);
        if_instr = mk(7'h00, 5'd1, 5'd2, 5'd10); if_pc = 32'h408;
        ex_load_pend = 1; ex_load_rd = 2;
        step();
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("rst_mid_valid", ex_valid, 0);
        chk("rst_mid_pc", ex_pc, 0);
        chk("rst_mid_cnt", dbg_stall_cnt, 0);
        @(negedge clk);
        rst_n = 1;

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            if_instr = mk(7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
            if_pc = $urandom;
            rf_rdata_a = $urandom; rf_rdata_b = $urandom;
            wb_we = $urandom_range(0, 1);
            wb_waddr = AW'($urandom_range(0, 7)); wb_wdata = $urandom;
            ex_load_pend = ($urandom_range(0, 3) == 0);
            ex_load_rd = AW'($urandom_range(0, 7));
            flush = ($urandom_range(0, 9) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
